stack_unit: RTL and testbench

Hardware operand stack for the multicycle stack CPU; sits directly downstream of the controller and consumes its `push`, `pop` and `tos` strobes. Holds operands in a LIFO register array and presents the popped or peeked word on a registered output that feeds the A/B operand registers. Push data arrives already muxed (memory data vs. ALU result, selected by `MtoS` outside this block). Detects overflow and underflow and reports them as sticky flags.

---
 rtl/stack_pkg.sv | 15 +
 rtl/stack_regfile.sv | 24 ++
 rtl/stack_unit.sv | 112 +++++++++++
 tb/tb_stack_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared constants and command encoding for the operand stack.
package stack_pkg;

  localparam int W_DEF     = 8;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    POP,
    PEEK,
    REPLACE
  } stack_cmd_t;

endpackage

// File: rtl/stack_regfile.sv
// Operand storage: one synchronous write port,
// one asynchronous read port.
module stack_regfile #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// LIFO operand stack with registered output
// and sticky overflow/underflow flags.
module stack_unit
  import stack_pkg::*;
#(
  parameter  int W     = W_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int SPW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic           tos,
  input  logic [W-1:0]   din,
  input  logic           err_clr,
  output logic [W-1:0]   dout,
  output logic [SPW-1:0] count,
  output logic           empty,
  output logic           full,
  output logic           overflow,
  output logic           underflow
);

  localparam int AW = $clog2(DEPTH);

  stack_cmd_t     cmd;
  logic [AW-1:0]  top_idx;
  logic [AW-1:0]  waddr;
  logic [W-1:0]   rdata;
  logic           we;
  logic [SPW-1:0] count_n;
  logic [W-1:0]   dout_n;
  logic           ovf_set;
  logic           unf_set;

  always_comb begin
    cmd = IDLE;
    unique case (1'b1)
      push && pop:          cmd = REPLACE;
      pop && !push:         cmd = POP;
      push && !pop:         cmd = PUSH;
      tos && !push && !pop: cmd = PEEK;
      default:              cmd = IDLE;
    endcase
  end

  assign empty   = (count == '0);
  assign full    = (count == SPW'(DEPTH));
  assign top_idx = AW'(count - SPW'(1));

  // Replace-top overwrites the current top; a plain push
  // writes the free slot at the count index.
  assign we    = (cmd == PUSH && !full) ||
                 (cmd == REPLACE && !empty);
  assign waddr = (cmd == REPLACE) ? top_idx
                                  : AW'(count);

  stack_regfile #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_rf (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (din),
    .raddr (top_idx),
    .rdata (rdata)
  );

  always_comb begin
    count_n = count;
    dout_n  = dout;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case (cmd)
      PUSH: begin
        if (full) ovf_set = 1'b1;
        else      count_n = count + SPW'(1);
      end
      POP: begin
        if (empty) begin
          unf_set = 1'b1;
        end else begin
          dout_n  = rdata;
          count_n = count - SPW'(1);
        end
      end
      REPLACE, PEEK: begin
        if (empty) unf_set = 1'b1;
        else       dout_n  = rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      dout      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_n;
      dout      <= dout_n;
      overflow  <= ovf_set | (overflow & ~err_clr);
      underflow <= unf_set | (underflow & ~err_clr);
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Directed table plus randomized run against a
// queue-based LIFO model.
module tb_stack_unit;
  import stack_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 8;
  localparam int SPW   = $clog2(DEPTH + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           push = 1'b0;
  logic           pop = 1'b0;
  logic           tos = 1'b0;
  logic [W-1:0]   din = '0;
  logic           err_clr = 1'b0;
  logic [W-1:0]   dout;
  logic [SPW-1:0] count;
  logic           empty;
  logic           full;
  logic           overflow;
  logic           underflow;

  int vectors = 0;
  int errors  = 0;

  stack_unit #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .tos       (tos),
    .din       (din),
    .err_clr   (err_clr),
    .dout      (dout),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pu;
    logic       po;
    logic       to;
    logic       clr;
    logic [7:0] d;
    logic [7:0] edout;
    int         ecnt;
    logic       eo;
    logic       eu;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic pu, po, to, clr,
                     input logic [7:0] d, edout,
                     input int ecnt,
                     input logic eo, eu);
    vec_t v;
    v.pu = pu; v.po = po; v.to = to; v.clr = clr;
    v.d = d; v.edout = edout; v.ecnt = ecnt;
    v.eo = eo; v.eu = eu;
    tbl.push_back(v);
  endtask

  task automatic check(input string name,
                       input logic [7:0] edout,
                       input int ecnt,
                       input logic eo, eu);
    logic [W+SPW+3:0] act, exp;
    act = {dout, count, empty, full, overflow, underflow};
    exp = {edout, SPW'(ecnt), ecnt == 0, ecnt == DEPTH,
           eo, eu};
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got dout=%h cnt=%0d e=%b f=%b o=%b u=%b, want dout=%h cnt=%0d e=%b f=%b o=%b u=%b",
               name, dout, count, empty, full, overflow,
               underflow, edout, ecnt, ecnt == 0,
               ecnt == DEPTH, eo, eu);
    end
  endtask

  task automatic apply(input string name,
                       input logic pu, po, to, clr,
                       input logic [7:0] d, edout,
                       input int ecnt,
                       input logic eo, eu);
    @(negedge clk);
    push = pu; pop = po; tos = to;
    err_clr = clr; din = d;
    @(posedge clk);
    #1;
    push = 0; pop = 0; tos = 0; err_clr = 0;
    check(name, edout, ecnt, eo, eu);
  endtask

  // Reference model state
  logic [7:0] stk[$];
  logic [7:0] m_dout;
  logic       m_ovf;
  logic       m_unf;

  task automatic model_step(input logic pu, po, to, clr,
                            input logic [7:0] d);
    logic ov, un;
    ov = 0; un = 0;
    if (pu && po) begin
      if (stk.size() == 0) un = 1;
      else begin
        m_dout = stk[$];
        stk[stk.size() - 1] = d;
      end
    end else if (po) begin
      if (stk.size() == 0) un = 1;
      else m_dout = stk.pop_back();
    end else if (pu) begin
      if (stk.size() == DEPTH) ov = 1;
      else stk.push_back(d);
    end else if (to) begin
      if (stk.size() == 0) un = 1;
      else m_dout = stk[$];
    end
    if (clr) begin m_ovf = 0; m_unf = 0; end
    m_ovf = m_ovf | ov;
    m_unf = m_unf | un;
  endtask

  initial begin
    // LIFO order
    add(0,0,0,0, 8'h00, 8'h00, 0, 0, 0);
    add(1,0,0,0, 8'h11, 8'h00, 1, 0, 0);
    add(1,0,0,0, 8'h22, 8'h00, 2, 0, 0);
    add(1,0,0,0, 8'h33, 8'h00, 3, 0, 0);
    add(0,1,0,0, 8'h00, 8'h33, 2, 0, 0);
    add(0,1,0,0, 8'h00, 8'h22, 1, 0, 0);
    add(0,1,0,0, 8'h00, 8'h11, 0, 0, 0);
    // peek then pop
    add(1,0,0,0, 8'h5A, 8'h11, 1, 0, 0);
    add(0,0,1,0, 8'h00, 8'h5A, 1, 0, 0);
    add(0,1,0,0, 8'h00, 8'h5A, 0, 0, 0);
    // fill and overflow
    for (int i = 1; i <= DEPTH; i++)
      add(1,0,0,0, 8'(i), 8'h5A, i, 0, 0);
    add(1,0,0,0, 8'hFF, 8'h5A, DEPTH, 1, 0);
    add(0,0,1,0, 8'h00, 8'(DEPTH), DEPTH, 1, 0);
    add(0,0,0,1, 8'h00, 8'(DEPTH), DEPTH, 0, 0);
    for (int i = DEPTH; i >= 1; i--)
      add(0,1,0,0, 8'h00, 8'(i), i - 1, 0, 0);
    // underflow
    add(0,1,0,0, 8'h00, 8'h01, 0, 0, 1);
    add(0,0,1,1, 8'h00, 8'h01, 0, 0, 1);
    add(0,0,0,1, 8'h00, 8'h01, 0, 0, 0);
    // replace-top
    add(1,0,0,0, 8'h07, 8'h01, 1, 0, 0);
    add(1,0,0,0, 8'h09, 8'h01, 2, 0, 0);
    add(1,1,0,0, 8'h10, 8'h09, 2, 0, 0);
    add(0,1,0,0, 8'h00, 8'h10, 1, 0, 0);
    add(0,1,0,0, 8'h00, 8'h07, 0, 0, 0);
    add(1,1,1,0, 8'hAA, 8'h07, 0, 0, 1);
    add(0,0,0,1, 8'h00, 8'h07, 0, 0, 0);
    // push while full plus tos: tos ignored
    for (int i = 1; i <= DEPTH; i++)
      add(1,0,0,0, 8'(8'h40 + i), 8'h07, i, 0, 0);
    add(1,0,1,0, 8'hEE, 8'h07, DEPTH, 1, 0);
    add(1,1,0,1, 8'hC3, 8'(8'h40 + DEPTH), DEPTH, 0, 0);
    add(0,1,0,0, 8'h00, 8'hC3, DEPTH - 1, 0, 0);

    rst = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;

    for (int i = 0; i < tbl.size(); i++)
      apply($sformatf("vec%0d", i), tbl[i].pu, tbl[i].po,
            tbl[i].to, tbl[i].clr, tbl[i].d,
            tbl[i].edout, tbl[i].ecnt, tbl[i].eo,
            tbl[i].eu);

    // Async reset in the middle of a cycle
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
    apply("pre_unf", 0,1,0,0, 8'h00, 8'h00, 0, 0, 1);
    apply("pre_p1", 1,0,0,0, 8'hA1, 8'h00, 1, 0, 1);
    apply("pre_p2", 1,0,0,0, 8'hA2, 8'h00, 2, 0, 1);
    apply("pre_p3", 1,1,0,0, 8'hA3, 8'hA2, 2, 0, 1);
    apply("pre_p4", 1,0,0,0, 8'hA4, 8'hA2, 3, 0, 1);
    @(posedge clk);
    #3 rst = 0;
    #1 check("async_rst", 8'h00, 0, 0, 0);
    @(negedge clk); rst = 1;
    apply("post_rst_pop", 0,1,0,0, 8'h00, 8'h00, 0, 0, 1);
    apply("post_rst_clr", 0,0,0,1, 8'h00, 8'h00, 0, 0, 0);

    // Randomized run against the model
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
    stk.delete();
    m_dout = 0; m_ovf = 0; m_unf = 0;
    for (int i = 0; i < 600; i++) begin
      logic pu, po, to, clr;
      logic [7:0] d;
      pu  = ($urandom_range(0, 99) < 50);
      po  = ($urandom_range(0, 99) < 35);
      to  = ($urandom_range(0, 99) < 25);
      clr = ($urandom_range(0, 99) < 8);
      d   = 8'($urandom);
      model_step(pu, po, to, clr, d);
      apply($sformatf("rnd%0d", i), pu, po, to, clr, d,
            m_dout, stk.size(), m_ovf, m_unf);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
